// File: rtl/serial_adder_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : serial_adder_ctrl
//  Description : Bit-serial add/subtract sequencer. One full-adder slice is
//                stepped over WIDTH-bit operands, LSB first, one bit per
//                clock. Start is a valid/ready handshake; completion is a
//                one-cycle done pulse with sum/cout/ovf held afterwards.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // Bit counter only has to reach WIDTH-1 (last step index).
  localparam int             c_cnt_w    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  // Operand shift registers: bit 0 of each is the slice input this cycle.
  logic [WIDTH-1:0]     r_opa;
  logic [WIDTH-1:0]     r_opb;
  // Collects the first WIDTH-1 result bits; the MSB goes straight to sum.
  logic [WIDTH-2:0]     r_shift;
  logic                 r_carry;
  logic [c_cnt_w-1:0]   r_count;

  logic                 w_accept;
  logic                 w_step;
  logic                 w_finish;
  logic                 w_bit;
  logic                 w_carry_nxt;
  logic [WIDTH-1:0]     w_shift_full;

  // Full-adder slice on the current operand LSBs.
  assign w_bit        = r_opa[0] ^ r_opb[0] ^ r_carry;
  assign w_carry_nxt  = (r_opa[0] & r_opb[0]) | (r_opa[0] & r_carry) | (r_opb[0] & r_carry);
  assign w_shift_full = {w_bit, r_shift};

  // State register; async reset returns straight to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode, datapath strobes and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    start_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        start_ready = 1'b1;
        // Accept takes priority over a concurrent abort, which is ignored here.
        if (start_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_count == c_last_cnt) begin
            w_finish    = 1'b1;
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand load on accept, then one shift/add step per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_shift <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
    end else if (w_accept) begin
      r_opa   <= a;
      // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
      r_opb   <= sub ? ~b : b;
      r_carry <= sub;
      r_count <= '0;
    end else if (w_step) begin
      r_opa   <= r_opa >> 1;
      r_opb   <= r_opb >> 1;
      r_shift <= w_shift_full[WIDTH-1:1];
      r_carry <= w_carry_nxt;
      // Counter parks at zero after the last step rather than wrapping.
      r_count <= w_finish ? '0 : (r_count + c_cnt_one);
    end
  end

  // Result registers update only on the completing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (w_finish) begin
      sum  <= w_shift_full;
      cout <= w_carry_nxt;
      // r_carry here is still the carry into the MSB slice.
      ovf  <= r_carry ^ w_carry_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder_ctrl
//  Description : Self-checking bench for serial_adder_ctrl (WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .sub         (sub),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] s;
    logic       c;
    logic       v;
  } vec_t;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       v;
    int         acc;
  } exp_t;

  vec_t       vecs[8];
  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] h_sum = 8'h00;
  logic       h_c = 1'b0;
  logic       h_v = 1'b0;
  logic       prev_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Reference arithmetic: {ovf, cout, sum}
  function automatic logic [9:0] model(input logic [7:0] ta, input logic [7:0] tb, input logic ts);
    logic [7:0] bb;
    logic [8:0] full;
    logic       v;
    bb   = ts ? ~tb : tb;
    full = {1'b0, ta} + {1'b0, bb} + {8'h00, ts};
    v    = (ta[7] == bb[7]) && (full[7] != ta[7]);
    return {v, full[8], full[7:0]};
  endfunction

  // Scoreboard monitor: pops an expectation on every done pulse and checks
  // the held result between pulses.
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) chk("done_width", 32'(done), 32'd0);
      if (done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("latency", 32'(cyc), 32'(e.acc + WIDTH));
          chk("sum",  32'(sum),  32'(e.s));
          chk("cout", 32'(cout), 32'(e.c));
          chk("ovf",  32'(ovf),  32'(e.v));
          h_sum = e.s;
          h_c   = e.c;
          h_v   = e.v;
        end
      end else begin
        chk("held_sum",  32'(sum),  32'(h_sum));
        chk("held_cout", 32'(cout), 32'(h_c));
        chk("held_ovf",  32'(ovf),  32'(h_v));
      end
      prev_done = done;
    end
  end

  task automatic wait_ready(output int acc);
    int ok;
    ok = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (start_ready) begin
        ok = 1;
        break;
      end
    end
    chk("ready_timeout", 32'(ok), 32'd1);
    acc = cyc + 1;
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                       input logic [7:0] es, input logic ec, input logic ev,
                       input logic with_abort);
    int   acc;
    exp_t e;
    @(posedge clk); #1;
    start_valid = 1'b1;
    a = ta; b = tb; sub = ts; abort = with_abort;
    wait_ready(acc);
    e.s = es; e.c = ec; e.v = ev; e.acc = acc;
    q.push_back(e);
    @(posedge clk); #1;
    start_valid = 1'b0;
    abort = 1'b0;
    a   = 8'($urandom_range(0, 255));
    b   = 8'($urandom_range(0, 255));
    sub = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("busy_after_accept",  32'(busy), 32'd1);
    chk("ready_after_accept", 32'(start_ready), 32'd0);
    drain();
  endtask

  initial begin
    int         e1, e2, acc;
    logic [9:0] m;
    logic [7:0] ra, rb;
    logic       rs;
    exp_t       e;

    vecs[0] = '{8'h35, 8'h1A, 1'b0, 8'h4F, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

    rst = 1'b1; start_valid = 1'b0; a = '0; b = '0; sub = 1'b0; abort = 1'b0;
    #2;
    chk("rst_ready", 32'(start_ready), 32'd1);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_sum",   32'(sum),  32'd0);
    chk("rst_cout",  32'(cout), 32'd0);
    chk("rst_ovf",   32'(ovf),  32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Table vectors; entry 3 also raises abort together with start_valid.
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].s, vecs[i].c, vecs[i].v, (i == 3));
    end

    // Random operations against the arithmetic model.
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      m  = model(ra, rb, rs);
      do_op(ra, rb, rs, m[7:0], m[8], m[9], 1'b0);
    end

    // start_valid held through a whole operation with new operands.
    @(posedge clk); #1;
    start_valid = 1'b1; a = 8'h11; b = 8'h22; sub = 1'b0;
    wait_ready(e1);
    e.s = 8'h33; e.c = 1'b0; e.v = 1'b0; e.acc = e1;
    q.push_back(e);
    @(posedge clk); #1;
    a = 8'h40; b = 8'h05; sub = 1'b1;
    wait_ready(e2);
    chk("second_accept_gap", 32'(e2 - e1), 32'd10);
    e.s = 8'h3B; e.c = 1'b1; e.v = 1'b0; e.acc = e2;
    q.push_back(e);
    @(posedge clk); #1;
    start_valid = 1'b0;
    drain();

    // Abort in the third RUN cycle, after a 0x4F result.
    do_op(8'h35, 8'h1A, 1'b0, 8'h4F, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    start_valid = 1'b1; a = 8'h01; b = 8'h01; sub = 1'b0;
    wait_ready(acc);
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(start_ready), 32'd1);
    chk("abort_busy",  32'(busy), 32'd0);
    chk("abort_sum",   32'(sum),  32'h4F);
    repeat (12) @(negedge clk);
    do_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-RUN, with nonzero prior results.
    do_op(8'h90, 8'h90, 1'b0, 8'h20, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    start_valid = 1'b1; a = 8'h55; b = 8'h22; sub = 1'b0;
    wait_ready(acc);
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    h_sum = 8'h00; h_c = 1'b0; h_v = 1'b0;
    #1;
    chk("mid_rst_busy",  32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(start_ready), 32'd1);
    chk("mid_rst_sum",   32'(sum),  32'd0);
    chk("mid_rst_cout",  32'(cout), 32'd0);
    chk("mid_rst_ovf",   32'(ovf),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(8'h02, 8'h03, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
